// File: rtl/tmr_seg7_pkg.sv
// Shared constants for the timer / 7-segment helper block.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package tmr_seg7_pkg;

    // Default timer counter width.
    localparam int CNT_W_DEF = 32;

    // Counter value at which the next enabled increment wraps.
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    // Width of one digit pattern.
    localparam int SEG_W = 7;

    // Hex digit segment patterns, active-high.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    // Timer action selected on a clock edge, in priority order.
    typedef enum logic [1:0] {
        TMR_CLR  = 2'd0,
        TMR_LOAD = 2'd1,
        TMR_CNT  = 2'd2,
        TMR_HOLD = 2'd3
    } tmr_op_e;

    // Resolve the clr > ld > tmr_en > hold priority.
    function automatic tmr_op_e tmr_op(
        input logic clr,
        input logic ld,
        input logic en
    );
        tmr_op_e op;
        op = TMR_HOLD;
        if (clr) begin
            op = TMR_CLR;
        end else if (ld) begin
            op = TMR_LOAD;
        end else if (en) begin
            op = TMR_CNT;
        end
        return op;
    endfunction

endpackage

// File: rtl/tmr_seg7_unit_hex_to_seg7.sv
// One hex digit to 7-segment pattern decoder.
// Purely combinational; optional inversion for common-anode parts.
module hex_to_seg7
    import tmr_seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg
);

    logic [SEG_W-1:0] w_code;

    // Map every nibble value to its active-high pattern.
    always_comb begin
        w_code = SEG_0;
        unique case (i_nib)
            4'h0: w_code = SEG_0;
            4'h1: w_code = SEG_1;
            4'h2: w_code = SEG_2;
            4'h3: w_code = SEG_3;
            4'h4: w_code = SEG_4;
            4'h5: w_code = SEG_5;
            4'h6: w_code = SEG_6;
            4'h7: w_code = SEG_7;
            4'h8: w_code = SEG_8;
            4'h9: w_code = SEG_9;
            4'hA: w_code = SEG_A;
            4'hB: w_code = SEG_B;
            4'hC: w_code = SEG_C;
            4'hD: w_code = SEG_D;
            4'hE: w_code = SEG_E;
            4'hF: w_code = SEG_F;
        endcase
    end

    assign o_seg = ACTIVE_LOW ? ~w_code : w_code;

endmodule

// File: rtl/tmr_seg7_unit.sv
// Loadable free-running interrupt timer plus dual hex digit decoder.
// tmr_req pulses for one cycle each time the counter wraps to zero.
module tmr_seg7_unit
    import tmr_seg7_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] din,
    input  logic             ld,
    input  logic             tmr_en,
    output logic             tmr_req,
    output logic [CNT_W-1:0] cntr_o,
    input  logic [7:0]       data,
    output logic [SEG_W-1:0] seg7led1,
    output logic [SEG_W-1:0] seg7led2
);

    localparam logic [CNT_W-1:0] L_MAX = '1;

    logic [CNT_W-1:0] r_cntr;
    logic             r_req;
    tmr_op_e          w_op;
    logic             w_at_max;

    assign w_op     = tmr_op(clr, ld, tmr_en);
    assign w_at_max = (r_cntr == L_MAX);

    // Counter and wrap request, updated by priority-resolved action.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cntr <= '0;
            r_req  <= 1'b0;
        end else begin
            unique case (w_op)
                TMR_CLR: begin
                    r_cntr <= '0;
                    r_req  <= 1'b0;
                end
                TMR_LOAD: begin
                    r_cntr <= din;
                    r_req  <= 1'b0;
                end
                TMR_CNT: begin
                    r_cntr <= r_cntr + 1'b1;
                    r_req  <= w_at_max;
                end
                default: begin
                    r_cntr <= r_cntr;
                    r_req  <= 1'b0;
                end
            endcase
        end
    end

    assign cntr_o  = r_cntr;
    assign tmr_req = r_req;

    hex_to_seg7 #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dig_lo (
        .i_nib (data[3:0]),
        .o_seg (seg7led1)
    );

    hex_to_seg7 #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dig_hi (
        .i_nib (data[7:4]),
        .o_seg (seg7led2)
    );

endmodule

// File: tb/tb_tmr_seg7_unit.sv
// Scoreboard bench for tmr_seg7_unit: driver pushes expectations,
// monitor pops and compares against both DUT variants.
module tb_tmr_seg7_unit;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] din;
    logic        ld;
    logic        tmr_en;
    logic [7:0]  data;

    logic        req_h;
    logic [31:0] cnt_h;
    logic [6:0]  s1_h;
    logic [6:0]  s2_h;
    logic        req_l;
    logic [31:0] cnt_l;
    logic [6:0]  s1_l;
    logic [6:0]  s2_l;

    tmr_seg7_unit #(.CNT_W(32), .SEG_ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .ld(ld),
        .tmr_en(tmr_en), .tmr_req(req_h), .cntr_o(cnt_h),
        .data(data), .seg7led1(s1_h), .seg7led2(s2_h)
    );

    tmr_seg7_unit #(.CNT_W(32), .SEG_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .ld(ld),
        .tmr_en(tmr_en), .tmr_req(req_l), .cntr_o(cnt_l),
        .data(data), .seg7led1(s1_l), .seg7led2(s2_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_seg;
        bit          low;
        string       name;
        logic [31:0] e_cnt;
        logic        e_req;
        logic [6:0]  e_s1;
        logic [6:0]  e_s2;
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int   checks = 0;
    int   errors = 0;

    logic [6:0] tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic push_tmr(input string nm, input logic [31:0] c,
                            input logic r);
        exp_t e;
        e.is_seg = 1'b0;
        e.low = 1'b0;
        e.name = nm;
        e.e_cnt = c;
        e.e_req = r;
        e.e_s1 = '0;
        e.e_s2 = '0;
        q.push_back(e);
        ->mon_ev;
    endtask

    // Drive inputs at negedge, expect state after the next posedge.
    task automatic step(input string nm, input logic r, input logic c,
                        input logic l, input logic en,
                        input logic [31:0] d,
                        input logic [31:0] ec, input logic er);
        @(negedge clk);
        rst = r;
        clr = c;
        ld = l;
        tmr_en = en;
        din = d;
        @(posedge clk);
        #1;
        push_tmr(nm, ec, er);
    endtask

    task automatic seg_chk(input string nm, input logic [7:0] d,
                           input logic [6:0] e1, input logic [6:0] e2);
        exp_t e;
        data = d;
        #1;
        e.is_seg = 1'b1;
        e.name = nm;
        e.e_cnt = '0;
        e.e_req = 1'b0;
        e.low = 1'b0;
        e.e_s1 = e1;
        e.e_s2 = e2;
        q.push_back(e);
        e.low = 1'b1;
        e.e_s1 = ~e1;
        e.e_s2 = ~e2;
        q.push_back(e);
        ->mon_ev;
        #1;
    endtask

    // Monitor: drain the scoreboard whenever the driver signals.
    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.is_seg) begin
                    logic [6:0] a1;
                    logic [6:0] a2;
                    a1 = e.low ? s1_l : s1_h;
                    a2 = e.low ? s2_l : s2_h;
                    checks++;
                    if (a1 !== e.e_s1 || a2 !== e.e_s2) begin
                        errors++;
                        $display("FAIL %s low=%0d: got %h/%h want %h/%h",
                                 e.name, e.low, a1, a2, e.e_s1, e.e_s2);
                    end
                end else begin
                    checks++;
                    if (cnt_h !== e.e_cnt || req_h !== e.e_req) begin
                        errors++;
                        $display("FAIL %s: got cnt=%h req=%b want cnt=%h req=%b",
                                 e.name, cnt_h, req_h, e.e_cnt, e.e_req);
                    end
                    checks++;
                    if (cnt_l !== e.e_cnt || req_l !== e.e_req) begin
                        errors++;
                        $display("FAIL %s(inv): got cnt=%h req=%b want cnt=%h req=%b",
                                 e.name, cnt_l, req_l, e.e_cnt, e.e_req);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        ld = 1'b0;
        tmr_en = 1'b0;
        din = '0;
        data = '0;
        #2;
        push_tmr("reset_init", 32'h0, 1'b0);

        step("rst_release", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0);
        step("load_1234", 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h1234, 1'b0);

        #3;
        rst = 1'b1;
        #1;
        push_tmr("async_rst", 32'h0, 1'b0);
        step("rst_hold1", 1'b1, 1'b0, 1'b1, 1'b1, 32'h99, 32'h0, 1'b0);
        step("rst_hold2", 1'b1, 1'b0, 1'b0, 1'b1, 32'h99, 32'h0, 1'b0);
        step("rst_off", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        step("load_10", 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h10, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step("count", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,
                 32'h10 + 32'(i), 1'b0);
        end

        step("load_fffe", 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE,
             32'hFFFF_FFFE, 1'b0);
        step("to_max", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,
             32'hFFFF_FFFF, 1'b0);
        step("wrap", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        step("after_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1, 1'b0);

        step("load_55", 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h55, 1'b0);
        step("clr_wins", 1'b0, 1'b1, 1'b1, 1'b1, 32'h77, 32'h0, 1'b0);
        step("ld_over_en", 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5, 32'hA5, 1'b0);

        step("load_max", 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step("hold_max", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                 32'hFFFF_FFFF, 1'b0);
        end
        step("clr_at_max", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

        seg_chk("seg_3F", 8'h3F, 7'h71, 7'h4F);
        seg_chk("seg_A0", 8'hA0, 7'h3F, 7'h77);
        for (int b = 0; b < 256; b++) begin
            logic [7:0] bv;
            bv = 8'(b);
            seg_chk("seg_sweep", bv, tbl[bv[3:0]], tbl[bv[7:4]]);
        end

        for (int t = 0; t < 100 && q.size() > 0; t++) begin
            #1;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0",
                     q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tmr_seg7_unit.md
Name: tmr_seg7_unit

Overview:
Peripheral helper block for the MIPS device-controller space. It combines a 32-bit loadable free-running interrupt timer with a dual-digit hexadecimal 7-segment display decoder.
- The timer is driven by controller command bits (clear, enable) and a word store to the timer data address.
- The decoder turns the byte latched by the controller into two 7-segment digit patterns.

Parameters:
- CNT_W, 32: timer counter width; din and cntr_o share this width.
- SEG_ACTIVE_LOW, 0: when 1, both segment outputs are inverted (common-anode displays).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous timer clear.
- din  in  32  timer load value.
- ld  in  1  synchronous load strobe; loads din into the counter.
- tmr_en  in  1  count enable.
- tmr_req  out  1  registered one-cycle overflow request.
- cntr_o  out  32  current counter value, registered.
- data  in  8  byte to display.
- seg7led1  out  7  low-nibble digit pattern (data[3:0]).
- seg7led2  out  7  high-nibble digit pattern (data[7:4]).

Behaviour:
- Reset (rst=1, asynchronous): cntr_o=0, tmr_req=0. The segment outputs are combinational and unaffected by reset.
- Timer priority each clock edge (rst=0): clr > ld > tmr_en > hold.
  - clr=1: cntr_o<=0, tmr_req<=0.
  - else ld=1: cntr_o<=din, tmr_req<=0. A load overrides counting in the same cycle.
  - else tmr_en=1: cntr_o<=cntr_o+1, modulo 2^32.
  - else: cntr_o holds, tmr_req<=0.
- Overflow:
  - When tmr_en=1, clr=0, ld=0 and cntr_o==32'hFFFF_FFFF, the next edge gives cntr_o=0 and tmr_req=1.
  - tmr_req is 0 on every other cycle, so it is a single-cycle pulse per wrap.
  - The counter keeps running after wrap. There is no sticky flag; the controller samples tmr_req directly.
- Latency:
  - A load is visible on cntr_o one cycle after the ld edge.
  - tmr_req rises in the same cycle cntr_o becomes 0 after wrap.
- Disabled timer: tmr_en=0 freezes the count and never raises tmr_req.
- Reset mid-count: the counter returns to 0 immediately, regardless of clk.
- Segment decode:
  - Purely combinational, zero latency; seg7led1 from data[3:0], seg7led2 from data[7:4].
  - Bit order of each output is {g,f,e,d,c,b,a}, with bit0 = segment a.
  - Active-high codes (before the SEG_ACTIVE_LOW inversion):
    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - All 16 nibble values are defined; there is no blank code.

Decomposition:
- Shared package tmr_seg7_pkg holds:
  - the 16-entry hex-to-segment code constants;
  - CNT_W default;
  - the all-ones overflow constant.
- One natural sub-module, hex_to_seg7: 4-bit nibble in, 7-bit pattern out, honouring SEG_ACTIVE_LOW. It is instantiated twice, once per digit.
- The counter stays inline in tmr_seg7_unit.

Test Plan:
- Reset: assert rst mid-count with cntr_o=0x0000_1234 -> cntr_o=0 and tmr_req=0 immediately, without a clock edge; both stay 0 until rst is released.
- Load and count: ld=1, din=0x0000_0010 for one cycle, then tmr_en=1 for 5 cycles -> cntr_o reads 0x10 then 0x11..0x15; tmr_req stays 0.
- Overflow pulse: load 0xFFFF_FFFE with tmr_en=1 -> cntr_o goes FFFF_FFFF, then 0 with tmr_req=1 for exactly one cycle, then 1 with tmr_req=0.
- Priority: clr=1, ld=1, tmr_en=1 together at cntr_o=0x55 -> cntr_o=0. Then ld=1, tmr_en=1 with din=0xA5 -> cntr_o=0xA5, not 0xA6.
- Hold: tmr_en=0 for 10 cycles at cntr_o=0xFFFF_FFFF -> value unchanged, tmr_req never asserted.
- Segment decode: data=0x3F gives seg7led1=0x71 (F) and seg7led2=0x4F (3); data=0xA0 gives seg7led1=0x3F and seg7led2=0x77. Sweep all 256 bytes against the code table, and repeat with SEG_ACTIVE_LOW=1 expecting inverted patterns.
